// File: rtl/croc_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// croc_gpio_pad_ctrl
//
// Board-level GPIO pad controller sitting between the croc_soc GPIO signals
// and the bidirectional board pins. Per pin it provides push-pull or
// open-drain drive, a multi-flop input synchroniser, an optional debounce
// filter, rise/fall edge pulses and sticky maskable pending flags that are
// ORed into one interrupt line.
//
// Parameters:
//   GpioCount      number of pins (>= 1)
//   SyncStages     synchroniser depth (>= 2)
//   DebounceCycles stable cycles needed to accept a new level when debounce
//                  is enabled (>= 1)
//
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   gpio_io        board pins (bidirectional)
//   gpio_o         output value from the SoC
//   gpio_out_en_o  output enable from the SoC (SoC-side name)
//   od_en_i        per-pin open-drain mode (1 = open-drain)
//   deb_en_i       per-pin debounce enable
//   gpio_i         filtered pin level towards the SoC
//   rise_o         one-cycle pulse on a filtered 0->1 transition
//   fall_o         one-cycle pulse on a filtered 1->0 transition
//   rise_mask_i    rise edges set the pending flag
//   fall_mask_i    fall edges set the pending flag
//   pending_clr_i  one-cycle clear of pending flags
//   pending_o      sticky pending flags
//   irq_o          OR of all pending flags
// -----------------------------------------------------------------------------
module croc_gpio_pad_ctrl #(
    parameter int unsigned GpioCount      = 16,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 1000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    inout  wire  [GpioCount-1:0] gpio_io,
    input  logic [GpioCount-1:0] gpio_o,
    input  logic [GpioCount-1:0] gpio_out_en_o,
    input  logic [GpioCount-1:0] od_en_i,
    input  logic [GpioCount-1:0] deb_en_i,
    output logic [GpioCount-1:0] gpio_i,
    output logic [GpioCount-1:0] rise_o,
    output logic [GpioCount-1:0] fall_o,
    input  logic [GpioCount-1:0] rise_mask_i,
    input  logic [GpioCount-1:0] fall_mask_i,
    input  logic [GpioCount-1:0] pending_clr_i,
    output logic [GpioCount-1:0] pending_o,
    output logic                 irq_o
);

    localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [GpioCount-1:0] pad_oe;
    logic [GpioCount-1:0] pad_out;

    logic [GpioCount-1:0] sync_p [SyncStages];
    logic [GpioCount-1:0] sync_lvl;

    logic [GpioCount-1:0] filt_p0;
    logic [GpioCount-1:0] filt_p1;
    logic [GpioCount-1:0] filt_d;
    logic [CntW-1:0]      cnt_q [GpioCount];
    logic [CntW-1:0]      cnt_d [GpioCount];

    logic [GpioCount-1:0] pending_q;
    logic [GpioCount-1:0] pending_d;

    // Pad drive: purely combinational so the pins behave even while in reset.
    // Open-drain only ever pulls low; a '1' is left to the board pull-up.
    assign pad_oe  = gpio_out_en_o & (~od_en_i | ~gpio_o);
    assign pad_out = gpio_o & ~od_en_i;

    for (genvar g = 0; g < GpioCount; g++) begin : g_pad
        assign gpio_io[g] = pad_oe[g] ? pad_out[g] : 1'bz;
    end

    // ---- stage: input synchroniser chain ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SyncStages; s++) begin
                sync_p[s] <= '0;
            end
        end else begin
            sync_p[0] <= gpio_io;
            for (int s = 1; s < SyncStages; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
        end
    end

    assign sync_lvl = sync_p[SyncStages-1];

    // Debounce: the counter only runs while the synchronised level disagrees
    // with the accepted level; any agreement restarts it from zero. With
    // debounce off the counter is parked at zero so re-enabling starts clean.
    always_comb begin
        filt_d = filt_p0;
        for (int i = 0; i < GpioCount; i++) begin
            cnt_d[i] = '0;
            if (!deb_en_i[i]) begin
                filt_d[i] = sync_lvl[i];
            end else if (sync_lvl[i] != filt_p0[i]) begin
                if (cnt_q[i] == CntLast) begin
                    filt_d[i] = sync_lvl[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    // ---- stage: filtered level and its one-cycle-delayed copy ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            filt_p0 <= '0;
            filt_p1 <= '0;
            for (int i = 0; i < GpioCount; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            filt_p0 <= filt_d;
            filt_p1 <= filt_p0;
            for (int i = 0; i < GpioCount; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign gpio_i = filt_p0;
    assign rise_o = filt_p0 & ~filt_p1;
    assign fall_o = ~filt_p0 & filt_p1;

    // A new edge in the same cycle as a clear keeps the flag set.
    assign pending_d = (pending_q & ~pending_clr_i)
                     | (rise_o & rise_mask_i)
                     | (fall_o & fall_mask_i);

    // ---- stage: sticky pending flags ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
    assign irq_o     = |pending_q;

endmodule

// File: tb/tb_croc_gpio_pad_ctrl.sv
// -----------------------------------------------------------------------------
// tb_croc_gpio_pad_ctrl
//
// Self-checking bench for croc_gpio_pad_ctrl with GpioCount=16, SyncStages=2,
// DebounceCycles=8. Pads are driven through the DUT's own push-pull drivers.
// Expected filtered/edge values are queued with their due cycle and compared
// when that cycle is reached.
// -----------------------------------------------------------------------------
module tb_croc_gpio_pad_ctrl;

    localparam int N   = 16;
    localparam int SYN = 2;
    localparam int DEB = 8;

    logic         clk;
    logic         rst_ni;
    wire  [N-1:0] pad;
    logic [N-1:0] gpio_o;
    logic [N-1:0] gpio_out_en_o;
    logic [N-1:0] od_en_i;
    logic [N-1:0] deb_en_i;
    logic [N-1:0] gpio_i;
    logic [N-1:0] rise_o;
    logic [N-1:0] fall_o;
    logic [N-1:0] rise_mask_i;
    logic [N-1:0] fall_mask_i;
    logic [N-1:0] pending_clr_i;
    logic [N-1:0] pending_o;
    logic         irq_o;

    croc_gpio_pad_ctrl #(
        .GpioCount      (N),
        .SyncStages     (SYN),
        .DebounceCycles (DEB)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .gpio_io       (pad),
        .gpio_o        (gpio_o),
        .gpio_out_en_o (gpio_out_en_o),
        .od_en_i       (od_en_i),
        .deb_en_i      (deb_en_i),
        .gpio_i        (gpio_i),
        .rise_o        (rise_o),
        .fall_o        (fall_o),
        .rise_mask_i   (rise_mask_i),
        .fall_mask_i   (fall_mask_i),
        .pending_clr_i (pending_clr_i),
        .pending_o     (pending_o),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pad;
        logic [N-1:0] exp_gpio;
        logic [N-1:0] exp_rise;
        logic [N-1:0] exp_fall;
    } vec_t;

    typedef struct {
        logic oe;
        logic o;
        logic od;
        logic exp_oe;
        logic exp_pad;
    } drv_t;

    typedef struct {
        int           due;
        string        tag;
        logic [N-1:0] gpio;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    vec_t tbl [9];
    drv_t dtbl [7];
    exp_t sb [$];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int lat, input string tag, input logic [N-1:0] g,
                        input logic [N-1:0] r, input logic [N-1:0] f);
        exp_t e;
        e.due  = cyc + lat;
        e.tag  = tag;
        e.gpio = g;
        e.rise = r;
        e.fall = f;
        sb.push_back(e);
    endtask

    // Advance one clock edge, sample 1 time unit later, retire due expectations.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            check({e.tag, "_gpio"}, gpio_i, e.gpio);
            check({e.tag, "_rise"}, rise_o, e.rise);
            check({e.tag, "_fall"}, fall_o, e.fall);
        end
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Bypass-mode vectors: pad levels and the outputs expected SYN+1 edges later.
        tbl[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[1] = '{16'h0020, 16'h0020, 16'h0020, 16'h0000};
        tbl[2] = '{16'h0020, 16'h0020, 16'h0000, 16'h0000};
        tbl[3] = '{16'hA5A0, 16'hA5A0, 16'hA580, 16'h0000};
        tbl[4] = '{16'h5A5A, 16'h5A5A, 16'h5A5A, 16'hA5A0};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h5A5A};
        tbl[6] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
        tbl[7] = '{16'hFFDF, 16'hFFDF, 16'h0000, 16'h0020};
        tbl[8] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFDF};

        // Pin 3 drive modes: {oe, o, od, driving, driven level}.
        dtbl[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        dtbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        dtbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        dtbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        dtbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        dtbl[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dtbl[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        rst_ni        = 1'b1;
        gpio_o        = '0;
        gpio_out_en_o = '1;
        od_en_i       = '0;
        deb_en_i      = '0;
        rise_mask_i   = '0;
        fall_mask_i   = '0;
        pending_clr_i = '0;
        #1 rst_ni = 1'b0;
        steps(2);

        check("rst_gpio", gpio_i, 16'h0000);
        check("rst_rise", rise_o, 16'h0000);
        check("rst_fall", fall_o, 16'h0000);
        check("rst_pending", pending_o, 16'h0000);
        check("rst_irq", {15'b0, irq_o}, 16'h0000);

        // Drive path is combinational and live during reset.
        for (int r = 0; r < 7; r++) begin
            gpio_out_en_o[3] = dtbl[r].oe;
            gpio_o[3]        = dtbl[r].o;
            od_en_i[3]       = dtbl[r].od;
            #1;
            check($sformatf("drive%0d_oe", r), {15'b0, dut.pad_oe[3]}, {15'b0, dtbl[r].exp_oe});
            if (dtbl[r].exp_oe) begin
                check($sformatf("drive%0d_pad", r), {15'b0, pad[3]}, {15'b0, dtbl[r].exp_pad});
            end
        end

        gpio_out_en_o = '1;
        gpio_o        = '0;
        od_en_i       = '0;
        step();
        rst_ni = 1'b1;
        steps(4);

        // Bypass latency and edge pulses.
        for (int t = 0; t < 9; t++) begin
            gpio_o = tbl[t].pad;
            push(SYN + 1, $sformatf("byp%0d", t), tbl[t].exp_gpio, tbl[t].exp_rise, tbl[t].exp_fall);
            step();
        end
        for (int k = 0; k < 8 && sb.size() > 0; k++) step();
        check("byp_drain", 16'(sb.size()), 16'h0000);

        // Debounce: a 7-cycle glitch on pin 5 is swallowed.
        deb_en_i = '1;
        steps(2);
        gpio_o = 16'h0020;
        for (int k = 0; k < 7; k++) begin
            step();
            check("glitch_gpio", gpio_i, 16'h0000);
            check("glitch_rise", rise_o, 16'h0000);
        end
        gpio_o = 16'h0000;
        for (int k = 0; k < 6; k++) begin
            step();
            check("glitch_gpio", gpio_i, 16'h0000);
            check("glitch_rise", rise_o, 16'h0000);
        end

        // Clean step is accepted exactly SYN+DEB edges later.
        gpio_o = 16'h0020;
        push(SYN + DEB - 1, "deb_early", 16'h0000, 16'h0000, 16'h0000);
        push(SYN + DEB,     "deb_step",  16'h0020, 16'h0020, 16'h0000);
        push(SYN + DEB + 1, "deb_after", 16'h0020, 16'h0000, 16'h0000);
        steps(SYN + DEB + 2);
        check("deb_drain", 16'(sb.size()), 16'h0000);

        // Debounce dropped mid-count: bypass takes over on the next edge.
        gpio_o = 16'h0000;
        steps(7);
        check("mode_cnt5", {12'b0, dut.cnt_q[5]}, 16'd5);
        check("mode_hold", gpio_i, 16'h0020);
        deb_en_i = '0;
        push(1, "mode_bypass", 16'h0000, 16'h0000, 16'h0020);
        step();
        check("mode_cnt0", {12'b0, dut.cnt_q[5]}, 16'd0);
        steps(2);

        // Pending and IRQ on pin 2.
        rise_mask_i = 16'h0004;
        gpio_o = 16'h0004;
        push(SYN + 1, "pend_rise", 16'h0004, 16'h0004, 16'h0000);
        steps(SYN + 1);
        check("pend_not_yet", pending_o, 16'h0000);
        step();
        check("pend_set", pending_o, 16'h0004);
        check("pend_irq", {15'b0, irq_o}, 16'h0001);
        step();
        pending_clr_i = 16'h0004;
        step();
        pending_clr_i = 16'h0000;
        check("pend_clr", pending_o, 16'h0000);
        check("pend_clr_irq", {15'b0, irq_o}, 16'h0000);

        // Clear coinciding with a new rise: set wins.
        gpio_o = 16'h0000;
        steps(SYN + 1);
        gpio_o = 16'h0004;
        steps(SYN + 1);
        check("win_rise", rise_o, 16'h0004);
        pending_clr_i = 16'h0004;
        step();
        pending_clr_i = 16'h0000;
        check("win_pending", pending_o, 16'h0004);
        check("win_irq", {15'b0, irq_o}, 16'h0001);

        // Mask changes leave pending bits alone; fall mask on pin 9.
        rise_mask_i = 16'h0000;
        fall_mask_i = 16'h0200;
        steps(2);
        check("mask_keep", pending_o, 16'h0004);
        gpio_o = 16'h0204;
        steps(SYN + 2);
        check("mask_rise_off", pending_o, 16'h0004);
        gpio_o = 16'h0004;
        steps(SYN + 1);
        check("fall9_pulse", fall_o, 16'h0200);
        step();
        check("fall9_pending", pending_o, 16'h0204);

        // Fill all pending bits, then start debounce counts and reset mid-count.
        rise_mask_i = '1;
        gpio_o = 16'hFFFF;
        steps(SYN + 2);
        check("fill_pending", pending_o, 16'hFFFF);
        deb_en_i = '1;
        gpio_o = 16'h0000;
        steps(SYN + 4);
        check("pre_rst_cnt", {12'b0, dut.cnt_q[0]}, 16'd4);
        check("pre_rst_gpio", gpio_i, 16'hFFFF);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_gpio", gpio_i, 16'h0000);
        check("arst_rise", rise_o, 16'h0000);
        check("arst_fall", fall_o, 16'h0000);
        check("arst_pending", pending_o, 16'h0000);
        check("arst_irq", {15'b0, irq_o}, 16'h0000);
        check("arst_cnt", {12'b0, dut.cnt_q[0]}, 16'd0);

        // Release with pads held high: one rise pulse after the bypass latency.
        gpio_o      = 16'hFFFF;
        deb_en_i    = '0;
        rise_mask_i = '0;
        steps(2);
        rst_ni = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            check($sformatf("rel%0d_gpio", n), gpio_i, (n >= SYN + 1) ? 16'hFFFF : 16'h0000);
            check($sformatf("rel%0d_rise", n), rise_o, (n == SYN + 1) ? 16'hFFFF : 16'h0000);
            check($sformatf("rel%0d_fall", n), fall_o, 16'h0000);
        end
        check("rel_pending", pending_o, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/croc_gpio_pad_ctrl.md
Name: croc_gpio_pad_ctrl

Overview:
Parametrised board-level GPIO pad controller for the croc FPGA tops. It sits between the croc_soc GPIO signals and the bidirectional board pins. Per pin it provides:
- push-pull or open-drain drive;
- multi-stage input synchronisation;
- optional digital debounce;
- rise/fall edge detection;
- sticky, maskable pending flags combined into a single interrupt line.

Parameters:
GpioCount, 16, number of GPIO pins (>=1).
SyncStages, 2, input synchroniser flop stages (>=2).
DebounceCycles, 1000, consecutive stable cycles required to accept a new level when debounce is enabled (>=1).

Ports:
clk_i  input  1  system clock.
rst_ni  input  1  asynchronous active-low reset.
gpio_io  inout  GpioCount  board pins.
gpio_o  input  GpioCount  output value from SoC.
gpio_out_en_o  input  GpioCount  output enable from SoC (SoC-side name retained).
od_en_i  input  GpioCount  per-pin open-drain mode (1 = open-drain).
deb_en_i  input  GpioCount  per-pin debounce enable.
gpio_i  output  GpioCount  filtered pin level to SoC.
rise_o  output  GpioCount  one-cycle pulse on filtered 0->1.
fall_o  output  GpioCount  one-cycle pulse on filtered 1->0.
rise_mask_i  input  GpioCount  rise edge sets pending.
fall_mask_i  input  GpioCount  fall edge sets pending.
pending_clr_i  input  GpioCount  one-cycle clear of pending bits.
pending_o  output  GpioCount  sticky pending flags.
irq_o  output  1  OR of pending_o.

Behaviour:
- One clock (clk_i); reset is asynchronous and active-low (rst_ni). All flops reset asynchronously.
- Reset values: gpio_i=0, rise_o=0, fall_o=0, pending_o=0, irq_o=0. All synchroniser flops and debounce counters are 0.
- Drive (combinational, no clock):
  - Push-pull (od_en_i[i]=0): gpio_io[i] = gpio_out_en_o[i] ? gpio_o[i] : Z.
  - Open-drain (od_en_i[i]=1): gpio_io[i] = (gpio_out_en_o[i] & ~gpio_o[i]) ? 0 : Z.
  - Drive is active during reset.
- Input path: gpio_io[i] feeds a SyncStages-deep flop chain giving sync[i]. filtered[i] is a register and gpio_i = filtered.
- Debounce disabled (deb_en_i[i]=0):
  - filtered <= sync every cycle.
  - Counter held at 0.
  - Latency from pad change to gpio_i: SyncStages+1 clock edges.
- Debounce enabled:
  - Counter cnt[i] has width $clog2(DebounceCycles+1).
  - If sync==filtered: cnt <= 0.
  - Else if cnt==DebounceCycles-1: filtered <= sync, cnt <= 0.
  - Else: cnt <= cnt+1.
  - A glitch shorter than DebounceCycles cycles (after sync) never reaches gpio_i. Any return to equality restarts the count.
  - Latency for a clean step: SyncStages+DebounceCycles edges.
- deb_en_i changes mid-count:
  - Falling to 0 clears cnt and switches to bypass on the next edge.
  - Rising to 1 starts counting from 0.
- Edge detect: filt_q is filtered delayed by one cycle. rise_o = filtered & ~filt_q and fall_o = ~filtered & filt_q (combinational from registers). Each pulse is high exactly in the first cycle gpio_i shows the new level.
- Pending:
  - set = (rise_o & rise_mask_i) | (fall_o & fall_mask_i).
  - pending <= (pending & ~pending_clr_i) | set.
  - Set wins over a simultaneous clear.
  - Mask changes do not affect bits already pending.
- irq_o = |pending_o, registered-source combinational (no extra latency).
- Reset deasserted with a pad held high: gpio_i rises after the normal latency and produces one rise_o pulse.
- Reset asserted mid-count or with pending set: everything returns to reset values immediately.

Test Plan:
- Push-pull/open-drain drive: GpioCount=16. Pin 3 with oe=1, o=1, od=0 -> pad driven 1. Set od=1 -> pad Z (pulled up). Set o=0 -> pad driven 0. Set oe=0 -> Z in both modes.
- Bypass latency: SyncStages=2, deb_en=0. Step pin 5 from 0 to 1 at edge k -> gpio_i[5]=1 and rise_o[5] pulses at edge k+3. A single-cycle rise_o pulse follows a later fall step the same way.
- Debounce: DebounceCycles=8, deb_en=1. 7-cycle high glitch -> gpio_i stays 0, no rise_o. Clean step -> gpio_i=1 exactly 2+8 edges later.
- Pending/IRQ: rise_mask[2]=1. Rise on pin 2 -> pending_o[2]=1 and irq_o=1 the next cycle. pending_clr_i[2] pulse -> both 0. Clear in the same cycle as a new rise -> pending stays 1.
- Mode switch and reset: deb_en dropped mid-count (cnt=5) -> bypass update on the next edge. rst_ni asserted with pending=0xFFFF and cnt non-zero -> all outputs 0 asynchronously; after release with pad high, one rise_o pulse is seen.
